// File: rtl/loopback_ber_checker_if.sv
// loopback_ber_checker_if: beat-level bus between the loopback tap and the BER checker.
// FIRST_ERR_CAPTURE_EN adds the first-error capture signals.
interface loopback_ber_checker_if #(
  parameter int WIDTH = 1,
  parameter int LAT_W = 10,
  parameter int CNT_W = 16
);
  logic en;
  logic start;
  logic [LAT_W-1:0] lat;
  logic [WIDTH-1:0] tx_data;
  logic [WIDTH-1:0] rx_data;
  logic [WIDTH-1:0] out;
  logic busy;
  logic done;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;
`ifdef FIRST_ERR_CAPTURE_EN
  logic first_err_valid;
  logic [CNT_W-1:0] first_err_beat;
  modport master (output en, start, lat, tx_data, rx_data,
                  input out, busy, done, err_count, bit_count, first_err_valid, first_err_beat);
  modport slave (input en, start, lat, tx_data, rx_data,
                 output out, busy, done, err_count, bit_count, first_err_valid, first_err_beat);
`else
  modport master (output en, start, lat, tx_data, rx_data,
                  input out, busy, done, err_count, bit_count);
  modport slave (input en, start, lat, tx_data, rx_data,
                 output out, busy, done, err_count, bit_count);
`endif
endinterface

// File: rtl/loopback_ber_checker.sv
// loopback_ber_checker: latency-compensated loopback bit-error counter over a fixed window.
// FIRST_ERR_CAPTURE_EN adds capture of the first erroneous beat index.
module loopback_ber_checker #(
  parameter int WIDTH = 1,
  parameter int MAX_LAT = 512,
  parameter int LAT_W = 10,
  parameter int WIN_LEN = 1024,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_ni,
  loopback_ber_checker_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_LAT);
  localparam int WIN_W = $clog2(WIN_LEN);
  localparam int C_W = WIN_W > LAT_W ? WIN_W : LAT_W;
  typedef enum logic [1:0] {IDLE, FILL, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mem_q [MAX_LAT];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr;
  logic [LAT_W:0] rsum;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d, bits_q, bits_d;
  logic [CNT_W:0] err_sum, bits_sum;
  logic [WIDTH-1:0] ref_tx, diff, out_q;
  logic start_ok, cmp_beat, last_fill, last_cmp;
`ifdef FIRST_ERR_CAPTURE_EN
  logic fev_q, fev_d;
  logic [CNT_W-1:0] feb_q, feb_d;
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q <= '0;
      lat_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      bits_q <= '0;
      out_q <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
      fev_q <= 1'b0;
      feb_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      lat_q <= lat_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      bits_q <= bits_d;
      out_q <= bus.en ? bus.rx_data : '0;
`ifdef FIRST_ERR_CAPTURE_EN
      fev_q <= fev_d;
      feb_q <= feb_d;
`endif
    end
  end
  always_ff @(posedge clk_i) if (bus.en) mem_q[wptr_q] <= bus.tx_data;
  // Read tap sits L entries behind the write pointer; L=MAX_LAT reads the slot about to be overwritten.
  always_comb begin
    rsum = (LAT_W+1)'(wptr_q) + (LAT_W+1)'(MAX_LAT) - (LAT_W+1)'(lat_q);
    rptr = rsum >= (LAT_W+1)'(MAX_LAT) ? PTR_W'(rsum - (LAT_W+1)'(MAX_LAT)) : PTR_W'(rsum);
    ref_tx = lat_q == '0 ? bus.tx_data : mem_q[rptr];
    diff = bus.rx_data ^ ref_tx;
    err_sum = {1'b0, err_q} + (CNT_W+1)'($countones(diff));
    bits_sum = {1'b0, bits_q} + (CNT_W+1)'(WIDTH);
    start_ok = state_q == IDLE && bus.en && bus.start;
    cmp_beat = state_q == CMP && bus.en;
    last_fill = cnt_q == C_W'(lat_q) - C_W'(1);
    last_cmp = cnt_q == C_W'(WIN_LEN - 1);
    wptr_d = !bus.en ? wptr_q : wptr_q == PTR_W'(MAX_LAT - 1) ? '0 : wptr_q + 1'b1;
    lat_d = !start_ok ? lat_q : bus.lat > LAT_W'(MAX_LAT) ? LAT_W'(MAX_LAT) : bus.lat;
    err_d = start_ok ? '0 : !cmp_beat ? err_q : err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    bits_d = start_ok ? '0 : !cmp_beat ? bits_q : bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
    state_d = start_ok ? (lat_d == '0 ? CMP : FILL)
            : state_q == DONE ? IDLE
            : state_q == FILL && bus.en && last_fill ? CMP
            : cmp_beat && last_cmp ? DONE : state_q;
    cnt_d = state_d != state_q ? '0 : bus.en ? cnt_q + 1'b1 : cnt_q;
`ifdef FIRST_ERR_CAPTURE_EN
    fev_d = start_ok ? 1'b0 : fev_q | (cmp_beat && |diff);
    feb_d = start_ok ? '0 : cmp_beat && |diff && !fev_q ? CNT_W'(cnt_q) : feb_q;
`endif
  end
  always_comb begin
    bus.busy = state_q == FILL || state_q == CMP;
    bus.done = state_q == DONE;
    bus.out = out_q;
    bus.err_count = err_q;
    bus.bit_count = bits_q;
`ifdef FIRST_ERR_CAPTURE_EN
    bus.first_err_valid = fev_q;
    bus.first_err_beat = feb_q;
`endif
  end
endmodule

// File: tb/tb_loopback_ber_checker.sv
// tb_loopback_ber_checker: randomized loopback scenarios checked against a beat-log reference model.
module tb_loopback_ber_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passes = 0, total = 0;
  int n = 0, dly = 0, lat_drv = 0, fbase = 0;
  bit flip_on = 1'b0;
  logic [7:0] txl[$], rxl[$];
  loopback_ber_checker_if #(.WIDTH(1), .LAT_W(5), .CNT_W(8)) b1 ();
  loopback_ber_checker_if #(.WIDTH(8), .LAT_W(5), .CNT_W(8)) b8 ();
  loopback_ber_checker #(.WIDTH(1), .MAX_LAT(16), .LAT_W(5), .WIN_LEN(32), .CNT_W(8))
    dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
  loopback_ber_checker #(.WIDTH(8), .MAX_LAT(16), .LAT_W(5), .WIN_LEN(32), .CNT_W(8))
    dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(b8.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive at negedge, let the edge happen, return at the next negedge for sampling.
  task automatic cycle(input bit e, input bit st, input bit st8);
    logic [7:0] t, r;
    t = 8'($urandom);
    r = 8'($urandom);
    if (e) begin
      txl.push_back(t);
      if (n >= dly) r = txl[n-dly];
      if (flip_on && (n - fbase == 3 || n - fbase == 10 || n - fbase == 31)) r ^= 8'd1;
      rxl.push_back(r);
    end
    b1.en = e; b1.start = st; b1.lat = st ? 5'(lat_drv) : 5'($urandom);
    b1.tx_data = t[0]; b1.rx_data = r[0];
    b8.en = e; b8.start = st8; b8.lat = '0; b8.tx_data = t; b8.rx_data = ~t;
    @(posedge clk);
    @(negedge clk);
    if (e) n++;
  endtask

  task automatic run_window(input string tag, input int lat_in, input int dly_in,
                            input int en_pct, input bit abuse, input bit flips);
    int s, L, exp_e, fe;
    bit got;
    dly = dly_in; lat_drv = lat_in; flip_on = flips;
    L = lat_in > 16 ? 16 : lat_in;
    s = n; fbase = s + L + 1;
    cycle(1'b1, 1'b1, 1'b0);
    chk({tag, "_busy"}, b1.busy, 1);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      bit e;
      int idx;
      e = $urandom_range(99) < en_pct;
      idx = n;
      cycle(e, abuse && $urandom_range(3) == 0, 1'b0);
      chk({tag, "_done_timing"}, b1.done, e && idx == s + L + 32);
      if (e) chk({tag, "_out"}, b1.out, rxl[idx][0]);
      else chk({tag, "_out_stall"}, b1.out, 0);
      got = b1.done;
    end
    chk({tag, "_done_seen"}, got, 1);
    if (got) begin
      exp_e = 0; fe = -1;
      for (int k = s + L + 1; k <= s + L + 32; k++) begin
        int d;
        d = int'((rxl[k] ^ txl[k-L]) & 8'd1);
        exp_e += d;
        if (d != 0 && fe < 0) fe = k - (s + L + 1);
      end
      chk({tag, "_err"}, b1.err_count, exp_e);
      chk({tag, "_bits"}, b1.bit_count, 32);
      chk({tag, "_busy_done"}, b1.busy, 0);
`ifdef FIRST_ERR_CAPTURE_EN
      chk({tag, "_fe_valid"}, b1.first_err_valid, fe >= 0);
      chk({tag, "_fe_beat"}, b1.first_err_beat, fe >= 0 ? fe : 0);
`endif
    end
    cycle(1'b1, 1'b0, 1'b0);
    chk({tag, "_done_single"}, b1.done, 0);
    chk({tag, "_err_hold"}, b1.bit_count, got ? 32 : b1.bit_count + 1);
  endtask

  initial begin
    bit got;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_err", b1.err_count, 0);
    chk("rst_bits", b1.bit_count, 0);
    chk("rst_out", b1.out, 0);
    rst_n = 1'b1;
    repeat (20) cycle(1'b1, 1'b0, 1'b0);
    run_window("perfect", 5, 5, 100, 1'b0, 1'b0);
    run_window("inject", 5, 5, 100, 1'b0, 1'b1);
    run_window("misalign", 4, 5, 100, 1'b0, 1'b0);
    run_window("clamp", 20, 16, 100, 1'b1, 1'b0);
    run_window("bypass_stall", 0, 0, 50, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      cycle(1'b1, 1'b0, 1'b0);
      got = b8.done;
    end
    chk("sat_done_seen", got, 1);
    chk("sat_err", b8.err_count, 255);
    chk("sat_bits", b8.bit_count, 255);
    dly = 1; lat_drv = 0; flip_on = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    chk("abort_busy_before", b1.busy, 1);
    chk("abort_bits_before", b1.bit_count, 10);
    rst_n = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    chk("abort_busy", b1.busy, 0);
    chk("abort_err", b1.err_count, 0);
    chk("abort_bits", b1.bit_count, 0);
    chk("abort_out", b1.out, 0);
    rst_n = 1'b1;
    got = 1'b0;
    repeat (40) begin
      cycle(1'b1, 1'b0, 1'b0);
      got = got | b1.done;
    end
    chk("abort_no_done", got, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
